// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types, constants and grant helper for mem_port_arbiter
//
// Purpose : FSM state encodings, port identifiers, the default wait limit
//           and the simultaneous-request arbitration helper.
// Ports   : none (package)
// Config  : ARB_ROUND_ROBIN_EN is consumed by mem_port_arbiter, not here.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } arb_port_e;

  localparam int DEFAULT_MAX_WAIT = 15;
  localparam int WAIT_CNT_W       = 8;

  // With both ports requesting: fixed mode favours DM (older instruction),
  // round-robin mode favours whichever port was not granted last.
  function automatic arb_port_e arb_pick(input logic      if_r,
                                         input logic      dm_r,
                                         input arb_port_e last,
                                         input logic      rr_en);
    if (if_r && dm_r) begin
      if (rr_en) return (last == PORT_DM) ? PORT_IF : PORT_DM;
      return PORT_DM;
    end
    if (if_r) return PORT_IF;
    return PORT_DM;
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// rtl/arb_wait_timer.sv - saturating wait-state counter with timeout compare
//
// Purpose : counts BUSY cycles without mem_ack; expire is high while the
//           current cycle is the MAX_WAIT-th such cycle (or later).
// Ports   : clk     in  clock, rising edge
//           rst     in  synchronous reset, active-high
//           clr     in  clear counter to 0 (wins over en)
//           en      in  increment (saturates at all-ones)
//           expire  out count has reached MAX_WAIT-1, i.e. this is the last allowed wait cycle
module arb_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter in front of a single-ported unified memory
//
// Purpose : serialises fetch (IF) and data (DM) requests onto one memory
//           port, holds the registered memory request until mem_ack, returns
//           data with a one-cycle ack, and ends unacknowledged transactions
//           after MAX_WAIT cycles with an err pulse.
// Ports   : CLK, RST                       clock / synchronous active-high reset
//           if_req, if_addr                fetch request (held until if_ack)
//           if_rdata, if_ack               fetch data + one-cycle completion
//           dm_req, dm_we, dm_addr, dm_wdata  data request (dm_we==0 is a read)
//           dm_rdata, dm_ack               load data + one-cycle completion
//           mem_req, mem_we, mem_addr, mem_wdata  registered memory request
//           mem_rdata, mem_ack             memory response
//           stall_if, stall_dm             pipeline freeze while a port waits
//           err                            pulses with the ack of a timed-out transaction
// Config  : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//           via rr_last; otherwise DM has fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            dm_req,
  input  logic [DW/8-1:0] dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ack,
  output logic            mem_req,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            stall_if,
  output logic            stall_dm,
  output logic            err
);

  arb_state_e      state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [DW/8-1:0] mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            dm_ack_q, dm_ack_d;
  logic            err_q, err_d;

  logic            tmr_clr, tmr_en, tmr_expire;
  logic            do_grant;
  arb_port_e       grant_port, pick_port;
  arb_port_e       rr_last;
  logic            if_eff, dm_eff;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
  arb_port_e rr_last_q, rr_last_d;
  assign rr_last = rr_last_q;
`else
  localparam logic RR_EN = 1'b0;
  assign rr_last = PORT_DM;
`endif

  // A requester still holds req during its ack cycle; masking with the
  // pending ack keeps that held request from being granted a second time.
  assign if_eff    = if_req & ~if_ack_q;
  assign dm_eff    = dm_req & ~dm_ack_q;
  assign pick_port = arb_pick(if_eff, dm_eff, rr_last, RR_EN);

  arb_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk   (CLK),
    .rst   (RST),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    do_grant    = 1'b0;
    grant_port  = pick_port;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (if_eff || dm_eff) do_grant = 1'b1;
      end
      ST_BUSY_IF: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_ack_d   = 1'b1;
          tmr_clr    = 1'b1;
          if (dm_eff) begin
            do_grant   = 1'b1;
            grant_port = PORT_DM;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end else if (tmr_expire) begin
          if_rdata_d = '0;
          if_ack_d   = 1'b1;
          err_d      = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
          tmr_clr    = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_BUSY_DM: begin
        if (mem_ack) begin
          dm_rdata_d = mem_rdata;
          dm_ack_d   = 1'b1;
          tmr_clr    = 1'b1;
          if (if_eff) begin
            do_grant   = 1'b1;
            grant_port = PORT_IF;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end else if (tmr_expire) begin
          dm_rdata_d = '0;
          dm_ack_d   = 1'b1;
          err_d      = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
          tmr_clr    = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        tmr_clr   = 1'b1;
      end
    endcase

    // Latching the winner's fields here covers both a grant from IDLE and a
    // back-to-back hand-over, where mem_req stays high without a gap.
    if (do_grant) begin
      mem_req_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_d = grant_port;
`endif
      if (grant_port == PORT_DM) begin
        state_d     = ST_BUSY_DM;
        mem_we_d    = dm_we;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
      end else begin
        state_d     = ST_BUSY_IF;
        mem_we_d    = '0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= PORT_DM;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_dm  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] PAT = 32'h5A00_C3C3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          dm_req = 1'b0;
  logic [3:0]    dm_we = '0;
  logic [31:0]   dm_addr = '0;
  logic [31:0]   dm_wdata = '0;
  logic [31:0]   dm_rdata;
  logic          dm_ack;
  logic          mem_req;
  logic [3:0]    mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          stall_if;
  logic          stall_dm;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int wait_states = 0;
  int wcnt = 0;
  logic mem_never = 1'b0;
  int n_if_ack = 0;
  int n_dm_ack = 0;
  int n_err = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(15)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_dm(stall_dm), .err(err)
  );

  always #5 CLK = ~CLK;

  // Memory model: acks after wait_states extra cycles, data = address ^ PAT.
  always @(negedge CLK) begin
    if (RST || !mem_req || mem_never) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt == wait_states) begin
      mem_ack = 1'b1;
      mem_rdata = mem_addr ^ PAT;
      wcnt = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
    if (if_ack === 1'b1) n_if_ack++;
    if (dm_ack === 1'b1) n_dm_ack++;
    if (err === 1'b1) n_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic single_fetch(input logic [31:0] addr, input string tag);
    if_req = 1'b1;
    if_addr = addr;
    #1;
    check({tag, " stall_if c0"}, stall_if, 1);
    tick();
    check({tag, " mem_req c1"}, mem_req, 1);
    check({tag, " mem_addr c1"}, mem_addr, addr);
    check({tag, " mem_we c1"}, mem_we, 0);
    check({tag, " if_ack c1"}, if_ack, 0);
    check({tag, " stall_if c1"}, stall_if, 1);
    tick();
    check({tag, " if_ack c2"}, if_ack, 1);
    check({tag, " if_rdata c2"}, if_rdata, addr ^ PAT);
    check({tag, " stall_if c2"}, stall_if, 0);
    if_req = 1'b0;
    tick();
    check({tag, " if_ack c3"}, if_ack, 0);
    check({tag, " mem_req c3"}, mem_req, 0);
  endtask

  // Both ports request together with 2 wait states; the first winner is
  // served in cycles 1-3 and the second takes over at cycle 4 without a gap.
  task automatic both_req(input logic dm_first, input string tag);
    logic [31:0] ia, da, fa, sa;
    ia = 32'h0000_0104;
    da = 32'h0000_0208;
    fa = dm_first ? da : ia;
    sa = dm_first ? ia : da;
    wait_states = 2;
    if_req = 1'b1; if_addr = ia;
    dm_req = 1'b1; dm_addr = da; dm_we = 4'b0000;
    tick();
    check({tag, " first addr"}, mem_addr, fa);
    tick(); tick();
    check({tag, " no ack c3"}, {if_ack, dm_ack}, 2'b00);
    tick();
    check({tag, " first ack c4"}, dm_first ? dm_ack : if_ack, 1);
    check({tag, " first data"}, dm_first ? dm_rdata : if_rdata, fa ^ PAT);
    check({tag, " no gap mem_req c4"}, mem_req, 1);
    check({tag, " second addr c4"}, mem_addr, sa);
    if (dm_first) dm_req = 1'b0; else if_req = 1'b0;
    tick(); tick();
    check({tag, " second pending c6"}, {if_ack, dm_ack}, 2'b00);
    tick();
    check({tag, " second ack c7"}, dm_first ? if_ack : dm_ack, 1);
    check({tag, " second data"}, dm_first ? if_rdata : dm_rdata, sa ^ PAT);
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    check({tag, " idle mem_req"}, mem_req, 0);
  endtask

  initial begin
    int a0, d0, e0, hi, early;
    logic exp_rr_first_dm;

    // Reset state
    RST = 1'b1;
    tick(); tick();
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst rdata", {if_rdata, dm_rdata}, 0);
    check("rst acks/err", {if_ack, dm_ack, err}, 0);
    check("rst stalls", {stall_if, stall_dm}, 0);
    RST = 1'b0;
    tick();

    // 1: single fetch, zero wait states
    wait_states = 0;
    single_fetch(32'h10, "t1");

    // 2: simultaneous after an IF grant -> DM first in either mode
    both_req(1'b1, "t2");

    // 3: after reset, four rounds of simultaneous requests
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_rr_first_dm = 1'b0;
`else
    exp_rr_first_dm = 1'b1;
`endif
    for (int r = 0; r < 4; r++) begin
      both_req(exp_rr_first_dm, $sformatf("t3r%0d", r));
    end

    // 4: store with 3 wait states, fields held stable, one ack
    wait_states = 3;
    d0 = n_dm_ack;
    dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 32'h20; dm_wdata = 32'hA5A5_1234;
    tick();
    dm_addr = 32'hFFFF_FFF0; dm_wdata = 32'h0; dm_we = 4'b1100;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("t4 fields c%0d", c), {mem_req, mem_we, mem_addr, mem_wdata},
            {1'b1, 4'b0011, 32'h20, 32'hA5A5_1234});
      tick();
    end
    check("t4 dm_ack", dm_ack, 1);
    check("t4 dm_rdata", dm_rdata, 32'h20 ^ PAT);
    dm_req = 1'b0; dm_we = 4'b0000;
    tick(); tick(); tick();
    check("t4 ack count", n_dm_ack - d0, 1);
    check("t4 idle", mem_req, 0);

    // 5: memory never acknowledges -> timeout after 15 cycles
    mem_never = 1'b1;
    e0 = n_err;
    dm_req = 1'b1; dm_addr = 32'h40;
    tick();
    hi = 0; early = 0;
    for (int c = 1; c <= 15; c++) begin
      if (mem_req === 1'b1) hi++;
      if (dm_ack === 1'b1 || err === 1'b1) early++;
      tick();
    end
    check("t5 mem_req cycles", hi, 15);
    check("t5 no early ack", early, 0);
    check("t5 ack+err", {dm_ack, err, mem_req}, 3'b110);
    check("t5 rdata zero", dm_rdata, 0);
    check("t5 stall_dm", stall_dm, 0);
    dm_req = 1'b0;
    tick();
    check("t5 pulse end", {dm_ack, err, mem_req}, 3'b000);
    check("t5 err count", n_err - e0, 1);

    // 6: reset while BUSY_DM, then a normal fetch
    a0 = n_if_ack + n_dm_ack;
    e0 = n_err;
    dm_req = 1'b1; dm_addr = 32'h60;
    tick(); tick();
    check("t6 busy", mem_req, 1);
    RST = 1'b1;
    tick();
    check("t6 after rst", {mem_req, dm_ack, if_ack, err}, 4'b0000);
    RST = 1'b0; dm_req = 1'b0; mem_never = 1'b0; wait_states = 0;
    tick();
    check("t6 no ack/err", {n_if_ack + n_dm_ack - a0, n_err - e0}, 0);
    single_fetch(32'h80, "t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
